add_accumulator: RTL and testbench
==================================

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 Parameter DW, default 4: data width of the adder sum term S_i.
REQ-002 Parameter AW, default 8: accumulator width.
REQ-003 Parameter LW, default 4: term-count width.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 start_i  input  1  begin a new accumulation run; sampled in IDLE only.
REQ-007 len_i  input  LW  number of terms in the run, sampled with start_i.
REQ-008 sum_valid_i  input  1  upstream 4-bit full-adder result valid.
REQ-009 S_i  input  DW  sum output of the upstream 4-bit full adder.
REQ-010 C_i  input  1  carry-out of the upstream 4-bit full adder.
REQ-011 sum_ready_o  output  1  block accepts a term this cycle.
REQ-012 out_ready_i  input  1  downstream accepts the result.
REQ-013 done_valid_o  output  1  acc_o/ovf_o hold a final result.
REQ-014 acc_o  output  AW  running/final accumulated value.
REQ-015 ovf_o  output  1  sticky overflow of acc_o during current run.
REQ-016 cnt_o  output  LW  number of terms accepted in current run.
REQ-017 busy_o  output  1  high in ACCUM or DONE.

Function
REQ-018 FSM SHALL have states IDLE, ACCUM, DONE.
REQ-019 IDLE: start_i=1 with len_i!=0 -> ACCUM; start_i=1 with len_i=0 -> DONE; else stay.
REQ-020 Start edge SHALL clear acc_o, ovf_o, cnt_o and latch len_i as remaining count.
REQ-021 sum_ready_o SHALL be 1 only in ACCUM; term accepted when sum_valid_i & sum_ready_o.
REQ-022 Accepted term value SHALL be {C_i, S_i} zero-extended to AW+1 bits (range 0..31 at defaults).
REQ-023 On accept: acc_o <= (acc_o + term) mod 2^AW; ovf_o <= ovf_o | carry-out of bit AW-1; cnt_o <= cnt_o + 1; visible the cycle after the accepting edge (1-cycle latency).
REQ-024 ACCUM -> DONE on the edge accepting term number len; no further terms accepted.
REQ-025 sum_valid_i outside ACCUM SHALL be ignored with no state change.
REQ-026 DONE: done_valid_o=1; acc_o, ovf_o, cnt_o held stable until out_ready_i=1.
REQ-027 DONE with out_ready_i=1 -> IDLE; acc_o, ovf_o, cnt_o retain values in IDLE until next start.
REQ-028 start_i in ACCUM or DONE SHALL be ignored.
REQ-029 done_valid_o SHALL be registered (state-decoded), never combinational from out_ready_i.

Reset
REQ-030 rst_i=1 SHALL force, asynchronously and regardless of state: state=IDLE, acc_o=0, ovf_o=0, cnt_o=0, remaining=0.
REQ-031 Outputs during/after reset: sum_ready_o=0, done_valid_o=0, busy_o=0; reset mid-run discards the partial sum.

Structure
REQ-032 FSM state encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and default widths SHALL live in shared package/include add_acc_pkg.
REQ-033 AW-bit addition with carry-out SHALL be a sub-module acc_adder; FSM, counters and registers in add_accumulator.

Verification
REQ-034 len_i=3, terms {C,S}=(0,5),(1,2),(0,15) -> done_valid_o=1 one cycle after 3rd accept, acc_o=8'd38, ovf_o=0, cnt_o=3.
REQ-035 len_i=9, all terms (1,15)=31 -> acc_o=8'd23 (279 mod 256), ovf_o=1, cnt_o=9.
REQ-036 len_i=0 with start_i -> DONE next cycle, acc_o=0, ovf_o=0, cnt_o=0, sum_ready_o never high.
REQ-037 Result held with out_ready_i=0 for 4 cycles while sum_valid_i=1, start_i=1 -> acc_o/cnt_o unchanged, sum_ready_o=0; out_ready_i=1 -> IDLE next cycle.
REQ-038 len_i=5, rst_i pulsed asynchronously after 2 accepts -> immediately IDLE, acc_o=0, cnt_o=0; new start len_i=1 term (0,7) -> acc_o=8'd7.
REQ-039 sum_valid_i toggling 1,0,1,0 in ACCUM with len_i=2, terms 4 and 6 -> only valid cycles accepted, acc_o=8'd10.

Source files
------------

// File: rtl/add_accumulator_pkg.sv
// add_acc_pkg: shared state encoding and default widths for the add accumulator
package add_acc_pkg;
    localparam int DW_DEF = 4;
    localparam int AW_DEF = 8;
    localparam int LW_DEF = 4;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/add_accumulator_if.sv
// add_accumulator_if: term stream, run control and result handshake of the accumulator
interface add_accumulator_if #(
    parameter int DW = 4,
    parameter int AW = 8,
    parameter int LW = 4
);
    logic          start_i;
    logic [LW-1:0] len_i;
    logic          sum_valid_i;
    logic [DW-1:0] S_i;
    logic          C_i;
    logic          sum_ready_o;
    logic          out_ready_i;
    logic          done_valid_o;
    logic [AW-1:0] acc_o;
    logic          ovf_o;
    logic [LW-1:0] cnt_o;
    logic          busy_o;
    modport master (
        output start_i, len_i, sum_valid_i, S_i, C_i, out_ready_i,
        input  sum_ready_o, done_valid_o, acc_o, ovf_o, cnt_o, busy_o
    );
    modport slave (
        input  start_i, len_i, sum_valid_i, S_i, C_i, out_ready_i,
        output sum_ready_o, done_valid_o, acc_o, ovf_o, cnt_o, busy_o
    );
endinterface

// File: rtl/acc_adder.sv
// acc_adder: AW-bit adder returning the wrapped sum and the carry out of the top bit
module acc_adder #(
    parameter int AW = 8
) (
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    output logic [AW-1:0] sum_o,
    output logic          co_o
);
    assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

// File: rtl/add_accumulator.sv
// add_accumulator: sums a run of len_i full-adder results {C,S} with sticky overflow
module add_accumulator
    import add_acc_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) (
    input logic clk_i,
    input logic rst_i,
    add_accumulator_if.slave bus
);
    state_t        state_q;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic          ovf_q;
    logic          co;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] rem_q;
    logic          ready_q;
    logic          done_q;
    logic          busy_q;
    logic          accept;

    assign accept = bus.sum_valid_i & ready_q;

    acc_adder #(.AW(AW)) u_adder (
        .a_i  (acc_q),
        .b_i  (AW'({bus.C_i, bus.S_i})),
        .sum_o(acc_d),
        .co_o (co)
    );

    // Run FSM with its datapath registers; outputs are registered state decodes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                        rem_q   <= bus.len_i;
                        busy_q  <= 1'b1;
                        state_q <= (bus.len_i != '0) ? ACCUM : DONE;
                        ready_q <= (bus.len_i != '0);
                        done_q  <= (bus.len_i == '0);
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_q | co;
                        cnt_q <= cnt_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == LW'(1)) begin
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sum_ready_o  = ready_q;
    assign bus.done_valid_o = done_q;
    assign bus.busy_o       = busy_q;
    assign bus.acc_o        = acc_q;
    assign bus.ovf_o        = ovf_q;
    assign bus.cnt_o        = cnt_q;
endmodule

// File: tb/tb_add_accumulator.sv
// tb_add_accumulator: directed vectors with hand-computed results for add_accumulator
module tb_add_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    add_accumulator_if #(.DW(4), .AW(8), .LW(4)) bus ();

    add_accumulator #(.DW(4), .AW(8), .LW(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [3:0] len);
        bus.start_i = 1'b1;
        bus.len_i   = len;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic push(input logic c, input logic [3:0] s);
        bus.sum_valid_i = 1'b1;
        bus.C_i         = c;
        bus.S_i         = s;
        tick();
        bus.sum_valid_i = 1'b0;
    endtask

    task automatic ack();
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        chk("ack_done", bus.done_valid_o, 0);
        chk("ack_busy", bus.busy_o, 0);
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.len_i       = '0;
        bus.sum_valid_i = 1'b0;
        bus.S_i         = '0;
        bus.C_i         = 1'b0;
        bus.out_ready_i = 1'b0;
        repeat (2) tick();
        chk("rst_ready", bus.sum_ready_o, 0);
        chk("rst_done", bus.done_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_acc", bus.acc_o, 0);
        chk("rst_cnt", bus.cnt_o, 0);
        chk("rst_ovf", bus.ovf_o, 0);
        rst = 1'b0;
        tick();
        // term presented while idle must be ignored
        push(1'b1, 4'd9);
        chk("idle_ign_acc", bus.acc_o, 0);
        chk("idle_ign_cnt", bus.cnt_o, 0);
        // three-term run
        start_run(4'd3);
        chk("r3_ready", bus.sum_ready_o, 1);
        chk("r3_busy", bus.busy_o, 1);
        push(1'b0, 4'd5);
        chk("r3_acc1", bus.acc_o, 5);
        chk("r3_cnt1", bus.cnt_o, 1);
        push(1'b1, 4'd2);
        chk("r3_acc2", bus.acc_o, 23);
        push(1'b0, 4'd15);
        chk("r3_acc", bus.acc_o, 38);
        chk("r3_cnt", bus.cnt_o, 3);
        chk("r3_ovf", bus.ovf_o, 0);
        chk("r3_done", bus.done_valid_o, 1);
        chk("r3_ready_off", bus.sum_ready_o, 0);
        // hold result under stray valid/start
        bus.sum_valid_i = 1'b1;
        bus.start_i     = 1'b1;
        bus.C_i         = 1'b1;
        bus.S_i         = 4'd15;
        bus.len_i       = 4'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_acc", bus.acc_o, 38);
            chk("hold_cnt", bus.cnt_o, 3);
            chk("hold_ready", bus.sum_ready_o, 0);
            chk("hold_done", bus.done_valid_o, 1);
        end
        bus.sum_valid_i = 1'b0;
        bus.start_i     = 1'b0;
        ack();
        chk("idle_keep_acc", bus.acc_o, 38);
        chk("idle_keep_cnt", bus.cnt_o, 3);
        // nine terms of 31 wrap past 255
        start_run(4'd9);
        for (int i = 0; i < 8; i++) push(1'b1, 4'd15);
        chk("r9_acc8", bus.acc_o, 248);
        chk("r9_ovf8", bus.ovf_o, 0);
        push(1'b1, 4'd15);
        chk("r9_acc", bus.acc_o, 23);
        chk("r9_ovf", bus.ovf_o, 1);
        chk("r9_cnt", bus.cnt_o, 9);
        chk("r9_done", bus.done_valid_o, 1);
        ack();
        chk("r9_keep_ovf", bus.ovf_o, 1);
        // zero-length run
        bus.sum_valid_i = 1'b1;
        start_run(4'd0);
        chk("r0_done", bus.done_valid_o, 1);
        chk("r0_ready", bus.sum_ready_o, 0);
        chk("r0_acc", bus.acc_o, 0);
        chk("r0_ovf", bus.ovf_o, 0);
        chk("r0_cnt", bus.cnt_o, 0);
        tick();
        chk("r0_ready2", bus.sum_ready_o, 0);
        chk("r0_acc2", bus.acc_o, 0);
        bus.sum_valid_i = 1'b0;
        ack();
        // asynchronous reset mid-run
        start_run(4'd5);
        push(1'b0, 4'd3);
        push(1'b0, 4'd4);
        chk("mr_acc2", bus.acc_o, 7);
        chk("mr_cnt2", bus.cnt_o, 2);
        #2 rst = 1'b1;
        #1;
        chk("mr_busy", bus.busy_o, 0);
        chk("mr_ready", bus.sum_ready_o, 0);
        chk("mr_acc", bus.acc_o, 0);
        chk("mr_cnt", bus.cnt_o, 0);
        #1 rst = 1'b0;
        tick();
        start_run(4'd1);
        push(1'b0, 4'd7);
        chk("r1_acc", bus.acc_o, 7);
        chk("r1_cnt", bus.cnt_o, 1);
        chk("r1_done", bus.done_valid_o, 1);
        ack();
        // gaps in valid
        start_run(4'd2);
        push(1'b0, 4'd4);
        chk("gap_acc1", bus.acc_o, 4);
        tick();
        chk("gap_acc_idle", bus.acc_o, 4);
        chk("gap_cnt_idle", bus.cnt_o, 1);
        push(1'b0, 4'd6);
        chk("gap_acc", bus.acc_o, 10);
        chk("gap_done", bus.done_valid_o, 1);
        tick();
        chk("gap_acc_hold", bus.acc_o, 10);
        chk("gap_cnt", bus.cnt_o, 2);
        ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
